// File: rtl/square_calculator_if.sv
// Request/result bundle for square_calculator: the requester drives start/in,
// the calculator returns out with done/error/busy status.
interface square_calculator_if #(
  parameter int unsigned IN_W  = 8,
  parameter int unsigned OUT_W = 2 * IN_W
);
  logic             start;
  logic [IN_W-1:0]  in;
  logic [OUT_W-1:0] out;
  logic             error;
  logic             done;
  logic             busy;

  modport master (output start, in, input out, error, done, busy);
  modport slave  (input start, in, output out, error, done, busy);
endinterface

// File: rtl/square_calculator.sv
// Sequential shift-add squarer: out = in*in over IN_W CALC cycles.
// Optional SQUARE_EARLY_EXIT_EN ends CALC once the remaining multiplier is zero.
module square_calculator #(
  parameter int unsigned IN_W  = 8,
  parameter int unsigned OUT_W = 2 * IN_W
) (
  input logic               clk,
  input logic               rst,
  square_calculator_if.slave bus
);
  localparam int unsigned CNT_W = (IN_W > 2) ? $clog2(IN_W) : 1;

  if (OUT_W != 2 * IN_W) begin : g_bad_out_w
    $error("square_calculator: OUT_W must equal 2*IN_W");
  end
  if (IN_W < 2) begin : g_bad_in_w
    $error("square_calculator: IN_W must be at least 2");
  end

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state;
  logic [OUT_W-1:0] a;
  logic [OUT_W-1:0] acc;
  logic [IN_W-1:0]  b;
  logic [CNT_W-1:0] cnt;

  logic [OUT_W-1:0] acc_next;
  logic [IN_W-1:0]  b_shift;
  logic             last;

  // One shift-add step and the exit condition for the current CALC cycle.
  always_comb begin
    acc_next = acc;
    b_shift  = b >> 1;
    last     = (cnt == CNT_W'(IN_W - 1));
    if (b[0]) begin
      acc_next = acc + (a << cnt);
    end
`ifdef SQUARE_EARLY_EXIT_EN
    if (b_shift == '0) begin
      last = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      a         <= '0;
      acc       <= '0;
      b         <= '0;
      cnt       <= '0;
      bus.out   <= '0;
      bus.done  <= 1'b0;
      bus.error <= 1'b0;
      bus.busy  <= 1'b0;
    end else begin
      bus.done  <= 1'b0;
      bus.error <= 1'b0;
      case (state)
        // DONE accepts a new request exactly like IDLE so requests can chain.
        IDLE, DONE: begin
          if (bus.start) begin
            a        <= OUT_W'(bus.in);
            b        <= bus.in;
            acc      <= '0;
            cnt      <= '0;
            bus.busy <= 1'b1;
            state    <= CALC;
          end else begin
            bus.busy <= 1'b0;
            state    <= IDLE;
          end
        end
        CALC: begin
          bus.error <= bus.start;
          acc       <= acc_next;
          b         <= b_shift;
          cnt       <= cnt + CNT_W'(1);
          if (last) begin
            bus.out  <= acc_next;
            bus.done <= 1'b1;
            bus.busy <= 1'b0;
            state    <= DONE;
          end
        end
        default: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_square_calculator.sv
// Directed bench for square_calculator: reset, basic squares, chaining,
// collision, full operand sweep and latency (fixed or early-exit build).
module tb_square_calculator;
  localparam int unsigned IN_W  = 8;
  localparam int unsigned OUT_W = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   done_cnt = 0;
  int   err_cnt  = 0;

  always #5 clk = ~clk;

  square_calculator_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

  square_calculator #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always @(negedge clk) begin
    if (bus.done)  done_cnt++;
    if (bus.error) err_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
  endtask

  // Cycles from start edge to the done cycle.
  function automatic int exp_lat(input logic [7:0] x);
    int m;
    m = 0;
`ifdef SQUARE_EARLY_EXIT_EN
    for (int i = 0; i < 8; i++) if (x[i]) m = i;
    return 2 + m;
`else
    m = x;
    return 9 + (m & 0);
`endif
  endfunction

  // Wait from the negedge after the start edge until done; k counts edges after it.
  task automatic wait_done(inout int k);
    while (!bus.done && k < 40) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic do_square(input string tag, input logic [7:0] x, input logic [15:0] exp_out,
                           input int lat);
    int k;
    @(negedge clk);
    bus.start = 1'b1;
    bus.in    = x;
    @(negedge clk);
    bus.start = 1'b0;
    bus.in    = 8'($urandom);
    k = 0;
    check({tag, "_busy"}, 32'(bus.busy), 32'd1);
    wait_done(k);
    check({tag, "_lat"}, 32'(k + 1), 32'(lat));
    check({tag, "_out"}, 32'(bus.out), 32'(exp_out));
    check({tag, "_busy_done"}, 32'(bus.busy), 32'd0);
    @(negedge clk);
    check({tag, "_done_width"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    int k;
    int d0;
    int e0;
    bus.start = 1'b0;
    bus.in    = '0;

    // Reset state
    #1;
    check("rst_out", 32'(bus.out), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_error", 32'(bus.error), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Basic squares
    do_square("sq0",   8'd0,   16'h0000, exp_lat(8'd0));
    do_square("sq1",   8'd1,   16'h0001, exp_lat(8'd1));
    do_square("sq15",  8'd15,  16'h00E1, exp_lat(8'd15));
    do_square("sq255", 8'd255, 16'hFE01, exp_lat(8'd255));
    do_square("sq3",   8'd3,   16'd9,    exp_lat(8'd3));
    do_square("sq128", 8'd128, 16'd16384, exp_lat(8'd128));
`ifdef SQUARE_EARLY_EXIT_EN
    check("early_lat0", 32'(exp_lat(8'd0)), 32'd2);
`endif

    // Back-to-back: second start lands in the DONE cycle
    e0 = err_cnt;
    @(negedge clk);
    bus.start = 1'b1;
    bus.in    = 8'd12;
    @(negedge clk);
    bus.start = 1'b0;
    bus.in    = 8'd99;
    k = 0;
    wait_done(k);
    check("b2b_lat1", 32'(k + 1), 32'(exp_lat(8'd12)));
    check("b2b_out1", 32'(bus.out), 32'd144);
    bus.start = 1'b1;
    bus.in    = 8'd13;
    @(negedge clk);
    bus.start = 1'b0;
    bus.in    = 8'd0;
    check("b2b_busy2", 32'(bus.busy), 32'd1);
    check("b2b_hold", 32'(bus.out), 32'd144);
    k = 0;
    wait_done(k);
    check("b2b_lat2", 32'(k + 1), 32'(exp_lat(8'd13)));
    check("b2b_out2", 32'(bus.out), 32'd169);
    @(negedge clk);
    check("b2b_no_error", 32'(err_cnt - e0), 32'd0);

    // Collision: second start three cycles into CALC
    @(negedge clk);
    bus.start = 1'b1;
    bus.in    = 8'd100;
    @(negedge clk);
    bus.start = 1'b0;
    bus.in    = 8'd0;
    k = 0;
    repeat (2) begin @(negedge clk); k++; end
    bus.start = 1'b1;
    bus.in    = 8'd7;
    @(negedge clk);
    k++;
    bus.start = 1'b0;
    check("col_error", 32'(bus.error), 32'd1);
    @(negedge clk);
    k++;
    check("col_error_width", 32'(bus.error), 32'd0);
    d0 = done_cnt;
    wait_done(k);
    check("col_lat", 32'(k + 1), 32'(exp_lat(8'd100)));
    check("col_out", 32'(bus.out), 32'd10000);
    repeat (14) @(negedge clk);
    check("col_one_done", 32'(done_cnt - d0), 32'd1);
    check("col_out_hold", 32'(bus.out), 32'd10000);

    // Reset mid-computation
    @(negedge clk);
    bus.start = 1'b1;
    bus.in    = 8'd200;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    check("rmid_busy", 32'(bus.busy), 32'd1);
    rst = 1'b0;
    #1;
    check("rmid_out", 32'(bus.out), 32'd0);
    check("rmid_done", 32'(bus.done), 32'd0);
    check("rmid_busy0", 32'(bus.busy), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    d0 = done_cnt;
    repeat (15) @(negedge clk);
    check("rmid_no_done", 32'(done_cnt - d0), 32'd0);
    check("rmid_out_after", 32'(bus.out), 32'd0);

    // Full operand sweep
    for (int x = 0; x < 256; x++) begin
      do_square("sweep", 8'(x), 16'(x * x), exp_lat(8'(x)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
